// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared entry type and word-index bounds for the store buffer.
//   sb_entry_t : one buffered store {addr, data, pc}
//   SB_IDX_LO/HI : byte-address bits holding the data-memory word index
package sb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_entry_t;
  localparam int SB_IDX_LO = 2;
  localparam int SB_IDX_HI = 13;
endpackage

// File: rtl/store_buffer_match.sv
// sb_match: finds the youngest occupied entry whose word index matches the load.
//   ent_i     : entry array
//   rd_ptr_i  : oldest entry slot
//   count_i   : occupancy
//   ld_addr_i : load byte address
//   hit_o     : some occupied entry matches
//   idx_o     : slot of youngest match (0 when no hit)
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = SB_IDX_HI - SB_IDX_LO + 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  sb_entry_t         ent_i [DEPTH],
  input  logic [PW-1:0]     rd_ptr_i,
  input  logic [CW-1:0]     count_i,
  input  logic [31:0]       ld_addr_i,
  output logic              hit_o,
  output logic [PW-1:0]     idx_o
);
  logic unused_bits;
  // Scan oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    unused_bits = ^ld_addr_i;
    for (int k = 0; k < DEPTH; k++) begin
      unused_bits = unused_bits ^ (^ent_i[k]);
      if (CW'(k) < count_i &&
          ent_i[rd_ptr_i + PW'(k)].addr[SB_IDX_LO +: IDX_W] == ld_addr_i[SB_IDX_LO +: IDX_W]) begin
        hit_o = 1'b1;
        idx_o = rd_ptr_i + PW'(k);
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO in front of data memory with load forwarding.
//   st_valid/st_ready/st_addr/st_data/st_pc : store push from MEM stage
//   ld_addr/ld_hit/ld_data                  : load forwarding (youngest match)
//   drain_en/dm_we/dm_addr/dm_wdata/dm_pc   : one-per-cycle drain to memory
//   count/empty/full                        : occupancy
// Optional: define STORE_BUFFER_TRACE_EN to print a store trace line on each drain.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [31:0]                st_pc,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hit,
  output logic [31:0]                ld_data,
  input  logic                       drain_en,
  output logic                       dm_we,
  output logic [31:0]                dm_addr,
  output logic [31:0]                dm_wdata,
  output logic [31:0]                dm_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  sb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, hit_idx;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  assign full     = count_q == CW'(DEPTH);
  assign empty    = count_q == '0;
  assign st_ready = !full;
  assign count    = count_q;
  assign push     = st_valid && !full;
  assign dm_we    = drain_en && !empty;
  assign dm_addr  = mem_q[rd_ptr_q].addr;
  assign dm_wdata = mem_q[rd_ptr_q].data;
  assign dm_pc    = mem_q[rd_ptr_q].pc;
  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = dm_we ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign count_d  = count_q + CW'(push) - CW'(dm_we);
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  // Entry contents need no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= '{addr: st_addr, data: st_data, pc: st_pc};
  sb_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_match (
    .ent_i     (mem_q),
    .rd_ptr_i  (rd_ptr_q),
    .count_i   (count_q),
    .ld_addr_i (ld_addr),
    .hit_o     (ld_hit),
    .idx_o     (hit_idx)
  );
  assign ld_data = ld_hit ? mem_q[hit_idx].data : '0;
`ifdef STORE_BUFFER_TRACE_EN
  always_ff @(posedge clk)
    if (dm_we && !reset) $display("%d@%h:*%h<=%h", $time, dm_pc, dm_addr, dm_wdata);
`else
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer.
module tb_store_buffer;
  logic        clk = 0, reset = 1, st_valid = 0, drain_en = 0;
  logic [31:0] st_addr = 0, st_data = 0, st_pc = 0, ld_addr = 0;
  logic        st_ready, ld_hit, dm_we, empty, full;
  logic [31:0] ld_data, dm_addr, dm_wdata, dm_pc;
  logic [2:0]  count;
  int          total = 0, bad = 0;
  logic [31:0] qa [$], qd [$];
  always #5 clk = ~clk;
  store_buffer dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .drain_en(drain_en), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc), .count(count),
    .empty(empty), .full(full)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    st_valid = 1; st_addr = a; st_data = d; st_pc = p;
    step();
    st_valid = 0;
  endtask
  initial begin
    logic [31:0] d2 [4];
    d2 = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
    step(); step();
    reset = 0;
    step();
    check("rst_empty", 32'(empty), 1);
    check("rst_ready", 32'(st_ready), 1);
    check("rst_full", 32'(full), 0);
    check("rst_we", 32'(dm_we), 0);
    check("rst_count", 32'(count), 0);
    check("rst_hit", 32'(ld_hit), 0);
    check("rst_ldata", ld_data, 0);
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), d2[i], 32'h400 + 32'(4 * i));
    st_valid = 1; st_addr = 32'h20; st_data = 32'hEEEE0005; st_pc = 32'h410;
    #1;
    check("full", 32'(full), 1);
    check("full_ready", 32'(st_ready), 0);
    check("full_count", 32'(count), 4);
    ld_addr = 32'h18;
    #1;
    check("full_fwd_hit", 32'(ld_hit), 1);
    check("full_fwd_data", ld_data, 32'hCCCC0003);
    step();
    st_valid = 0;
    check("push_ignored_count", 32'(count), 4);
    drain_en = 1; ld_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_we", 32'(dm_we), 1);
      check("drain_addr", dm_addr, 32'h10 + 32'(4 * i));
      check("drain_data", dm_wdata, d2[i]);
      check("drain_pc", dm_pc, 32'h400 + 32'(4 * i));
      if (i == 0) check("drain_fwd", ld_data, 32'hAAAA0001);
      step();
    end
    check("drained_empty", 32'(empty), 1);
    check("drained_we", 32'(dm_we), 0);
    check("drained_hit", 32'(ld_hit), 0);
    drain_en = 0;
    push(32'h40, 32'h1, 32'h500);
    push(32'h44, 32'h2, 32'h504);
    push(32'h40, 32'h3, 32'h508);
    ld_addr = 32'h40; #1;
    check("young_hit", 32'(ld_hit), 1);
    check("young_data", ld_data, 32'h3);
    ld_addr = 32'h43; #1;
    check("unaligned_hit", 32'(ld_hit), 1);
    check("unaligned_data", ld_data, 32'h3);
    ld_addr = 32'h48; #1;
    check("miss_hit", 32'(ld_hit), 0);
    check("miss_data", ld_data, 0);
    st_valid = 1; st_addr = 32'h48; st_data = 32'h9; #1;
    check("same_cycle_push_invisible", 32'(ld_hit), 0);
    st_valid = 0;
    drain_en = 1;
    step();
    check("pre_steady_count", 32'(count), 2);
    qa = '{32'h44, 32'h40};
    qd = '{32'h2, 32'h3};
    for (int i = 0; i < 8; i++) begin
      st_valid = 1; st_addr = 32'h100 + 32'(4 * i); st_data = 32'h5000 + 32'(i);
      #1;
      check("steady_we", 32'(dm_we), 1);
      check("steady_addr", dm_addr, qa[0]);
      check("steady_data", dm_wdata, qd[0]);
      void'(qa.pop_front()); void'(qd.pop_front());
      qa.push_back(st_addr); qd.push_back(st_data);
      step();
      check("steady_count", 32'(count), 2);
    end
    drain_en = 0;
    push(32'h200, 32'h77, 32'h600);
    check("pre_reset_count", 32'(count), 3);
    drain_en = 1; reset = 1;
    step();
    reset = 0;
    #1;
    check("post_reset_we", 32'(dm_we), 0);
    check("post_reset_count", 32'(count), 0);
    check("post_reset_empty", 32'(empty), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO directly upstream of the data memory in the pipelined CPU.
- Accepts committed stores (address, data, PC) from the MEM stage and drains them one per cycle into the data memory's single write port.
- Forwards buffered data to same-stage loads, so loads always see program-order memory contents.
- Decouples store issue from memory-port availability (`drain_en`).

Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2.
- IDX_W, 12, word-index width compared for forwarding (address bits [13:2], matching the 4096-word data memory).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  store request this cycle.
- st_ready  output  1  buffer can accept a store; equals !full.
- st_addr  input  32  byte address of store.
- st_data  input  32  store data.
- st_pc  input  32  PC of the store instruction.
- ld_addr  input  32  byte address of the current MEM-stage load.
- ld_hit  output  1  ld_addr word matches a buffered entry.
- ld_data  output  32  data of the youngest matching entry; 0 when !ld_hit.
- drain_en  input  1  memory write port is free this cycle.
- dm_we  output  1  write strobe to data memory.
- dm_addr  output  32  write byte address.
- dm_wdata  output  32  write data.
- dm_pc  output  32  PC of the draining store.
- count  output  $clog2(DEPTH+1)  occupancy.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Storage and state:
  - Circular FIFO with rd_ptr, wr_ptr (log2 DEPTH bits each, wrap naturally) and a count register.
  - Each entry holds {addr, data, pc}; no per-entry valid bit, occupancy is derived from the pointers.
- Reset:
  - rd_ptr = wr_ptr = count = 0.
  - Resulting outputs: empty=1, full=0, st_ready=1, dm_we=0, ld_hit=0, ld_data=0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all pending stores; none are written to memory.
- Push:
  - Occurs when st_valid && st_ready.
  - Entry written at wr_ptr on the clock edge; wr_ptr increments.
  - st_valid while full is ignored; the upstream pipeline holds the store and stalls.
- Drain:
  - Combinational outputs: dm_we = drain_en && !empty; dm_addr/dm_wdata/dm_pc = entry at rd_ptr.
  - On the edge where dm_we=1, rd_ptr increments.
  - Memory commits on the same edge, so the latency from push to memory write is ≥1 cycle.
- Simultaneous push and drain:
  - Allowed whenever !full; count is unchanged.
  - No push when full, even if a drain occurs that cycle; st_ready is not dependent on drain_en.
- Count update: count += push − pop, saturating impossible by construction.
- Forwarding (combinational):
  - Compares ld_addr[13:2] against addr[13:2] of every occupied entry, including the entry draining this cycle, because memory is not yet updated before the edge.
  - If several entries match, the youngest (closest to wr_ptr−1) wins.
  - A store being pushed in the same cycle is not visible; only one memory instruction is in MEM per cycle.
  - Occupancy test per entry: ((i − rd_ptr) mod DEPTH) < count.
- Alignment and width: word stores only; addr[1:0] are ignored for matching and passed through unchanged on dm_addr.

Optional Feature:
- Macro: STORE_BUFFER_TRACE_EN.
- Defined: on each drain edge (dm_we && !reset), prints `"%d@%h:*%h<=%h"` with $time, dm_pc, dm_addr, dm_wdata. This preserves the CPU's store-trace format at the moment memory is actually written.
- Undefined: no $display; RTL is otherwise identical.

Decomposition:
- Package sb_pkg holds:
  - typedef sb_entry_t {addr[31:0], data[31:0], pc[31:0]};
  - constants SB_IDX_LO=2, SB_IDX_HI=13.
- One sub-module, sb_match: takes the entry array, rd_ptr and count; returns hit plus the youngest matching index (age-ordered priority scan).
- FIFO pointers, counters and drain logic stay in store_buffer.

Test Plan:
1. Reset, then idle → empty=1, st_ready=1, dm_we=0, count=0, ld_hit=0.
2. drain_en=0; push 0x10←0xAAAA0001, 0x14←0xBBBB0002, 0x18←0xCCCC0003, 0x1C←0xDDDD0004 → full=1, st_ready=0, count=4. A 5th push (0x20) is ignored; count stays 4.
3. From full, drain_en=1 for 4 cycles → dm_we=1 each cycle, dm_addr sequence 0x10,0x14,0x18,0x1C with matching data, then empty=1, dm_we=0.
4. drain_en=0; push 0x40←0x1, 0x44←0x2, 0x40←0x3; ld_addr=0x40 → ld_hit=1, ld_data=0x3 (youngest). ld_addr=0x43 → also hits 0x3. ld_addr=0x48 → ld_hit=0, ld_data=0.
5. Steady state, count=2, drain_en=1, push every cycle for 8 cycles → count stays 2. Pointers wrap past DEPTH, and the drain order equals the push order.
6. count=3 with drain_en=1; assert reset for one cycle → dm_we is low in the cycle after reset, count=0. The reset-cycle drain does not reach memory (memory reset also dominates).
